// File: rtl/seq_loader.sv
// seq_loader: collects one frame of symbols (A[1..N] then B[1..M]) from a
// valid/ready stream, then drives a one-cycle clear pulse and a one-cycle
// start pulse to an alignment array. It waits for the array's done level to
// rise, captures the array's score and reports it. Malformed frames are
// dropped and flagged without touching the array.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   in_valid     upstream word valid
//   in_data      upstream symbol word (W bits)
//   in_last      marks the final word of a frame
//   in_ready     loader accepts a word this cycle
//   seq_a        A[k] at bits [k*W-1:(k-1)*W], k=1..N
//   seq_b        B[k] at bits [k*W-1:(k-1)*W], k=1..M
//   arr_clr      one-cycle clear pulse to the array
//   arr_start    one-cycle start pulse to the array
//   arr_done     finish level from the array
//   arr_score    solution value from the array
//   score        score captured from the last completed run
//   score_valid  one-cycle pulse when score updates
//   frame_err    one-cycle pulse when a malformed frame is dropped
module seq_loader #(
    parameter int N = 5,
    parameter int M = 5,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    input  logic           in_last,
    output logic           in_ready,
    output logic [N*W-1:0] seq_a,
    output logic [M*W-1:0] seq_b,
    output logic           arr_clr,
    output logic           arr_start,
    input  logic           arr_done,
    input  logic [W-1:0]   arr_score,
    output logic [W-1:0]   score,
    output logic           score_valid,
    output logic           frame_err
);

    localparam int MAXNM = (N > M) ? N : M;
    localparam int CW    = $clog2(MAXNM + 1);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        CLEAR  = 3'd2,
        FIRE   = 3'd3,
        WAIT   = 3'd4
    } state_t;

    state_t         state_r;
    logic [CW-1:0]  cnt_r;
    logic [W-1:0]   a_r [N];
    logic [W-1:0]   b_r [M];
    logic [W-1:0]   score_r;
    logic           done_r;
    logic           in_ready_r;
    logic           arr_clr_r;
    logic           arr_start_r;
    logic           score_valid_r;
    logic           frame_err_r;

    logic           accept_s;
    logic           rise_s;

    assign accept_s = in_valid & in_ready_r;
    // done_r tracks arr_done every cycle, so a level already high when WAIT
    // is entered never looks like a rising edge.
    assign rise_s   = arr_done & ~done_r;

    // Frame loading FSM, array handshake and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= LOAD_A;
            cnt_r         <= '0;
            score_r       <= '0;
            done_r        <= 1'b0;
            in_ready_r    <= 1'b1;
            arr_clr_r     <= 1'b0;
            arr_start_r   <= 1'b0;
            score_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            for (int k = 0; k < N; k++) a_r[k] <= '0;
            for (int k = 0; k < M; k++) b_r[k] <= '0;
        end else begin
            arr_clr_r     <= 1'b0;
            arr_start_r   <= 1'b0;
            score_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            done_r        <= arr_done;
            case (state_r)
                LOAD_A: begin
                    if (accept_s) begin
                        for (int k = 0; k < N; k++) begin
                            if (cnt_r == CW'(k)) a_r[k] <= in_data;
                        end
                        if (in_last) begin
                            // in_last can never legally land inside A
                            frame_err_r <= 1'b1;
                            cnt_r       <= '0;
                        end else if (cnt_r == CW'(N - 1)) begin
                            state_r <= LOAD_B;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (accept_s) begin
                        for (int k = 0; k < M; k++) begin
                            if (cnt_r == CW'(k)) b_r[k] <= in_data;
                        end
                        if (cnt_r == CW'(M - 1)) begin
                            cnt_r <= '0;
                            if (in_last) begin
                                state_r    <= CLEAR;
                                in_ready_r <= 1'b0;
                                arr_clr_r  <= 1'b1;
                            end else begin
                                // frame too long: drop it and resync on A
                                state_r     <= LOAD_A;
                                frame_err_r <= 1'b1;
                            end
                        end else if (in_last) begin
                            state_r     <= LOAD_A;
                            cnt_r       <= '0;
                            frame_err_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                end
                CLEAR: begin
                    state_r     <= FIRE;
                    arr_start_r <= 1'b1;
                end
                FIRE: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (rise_s) begin
                        state_r       <= LOAD_A;
                        score_r       <= arr_score;
                        score_valid_r <= 1'b1;
                        in_ready_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= LOAD_A;
                    cnt_r      <= '0;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign arr_clr     = arr_clr_r;
    assign arr_start   = arr_start_r;
    assign score       = score_r;
    assign score_valid = score_valid_r;
    assign frame_err   = frame_err_r;

    for (genvar k = 0; k < N; k++) begin : g_pack_a
        assign seq_a[k*W +: W] = a_r[k];
    end

    for (genvar k = 0; k < M; k++) begin : g_pack_b
        assign seq_b[k*W +: W] = b_r[k];
    end

endmodule

// File: doc/seq_loader.md
SEQ_LOADER -- requirements
Module: seq_loader

Interface
REQ-001 Parameter N, default 5: length of sequence A, in symbols.
REQ-002 Parameter M, default 5: length of sequence B, in symbols.
REQ-003 Parameter W, default 32: width of one symbol and of the score, in bits.
REQ-004 clk  input  1: single clock; all state changes on the rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 in_valid  input  1: the upstream symbol word is valid.
REQ-007 in_data  input  W: symbol word; frame order is A[1..N] then B[1..M].
REQ-008 in_last  input  1: marks the final word of a frame.
REQ-009 in_ready  output  1: the loader accepts a word this cycle.
REQ-010 seq_a  output  N*W: A[k] held at bits [k*W-1:(k-1)*W], k=1..N.
REQ-011 seq_b  output  M*W: B[k] held at bits [k*W-1:(k-1)*W], k=1..M.
REQ-012 arr_clr  output  1: one-cycle clear pulse to the alignment array.
REQ-013 arr_start  output  1: one-cycle start pulse to the alignment array.
REQ-014 arr_done  input  1: finish level from the alignment array.
REQ-015 arr_score  input  W: solution value from the alignment array.
REQ-016 score  output  W: score captured from the last completed run.
REQ-017 score_valid  output  1: one-cycle pulse when score updates.
REQ-018 frame_err  output  1: one-cycle pulse when a malformed frame is dropped.

Function
REQ-019 The loader SHALL be an FSM with the states LOAD_A, LOAD_B, CLEAR, FIRE and WAIT.
REQ-020 A word SHALL be accepted only in a cycle with in_valid=1 and in_ready=1.
REQ-021 in_ready SHALL be 1 in LOAD_A and LOAD_B, and 0 in CLEAR, FIRE and WAIT.
REQ-022 LOAD_A: each accepted word SHALL be written to A[cnt+1] and cnt SHALL increment; after the N-th word the FSM SHALL go to LOAD_B with cnt=0.
REQ-023 LOAD_B: each accepted word SHALL be written to B[cnt+1] and cnt SHALL increment; after the M-th word with in_last=1 the FSM SHALL go to CLEAR.
REQ-024 A word accepted with in_last=1 in LOAD_A, or in LOAD_B before the M-th word, SHALL pulse frame_err the next cycle, zero cnt and return the FSM to LOAD_A.
REQ-025 The M-th B word accepted with in_last=0 SHALL pulse frame_err, zero cnt and return the FSM to LOAD_A.
REQ-026 A dropped frame SHALL NOT produce arr_clr or arr_start; seq_a and seq_b may hold partial data and are overwritten by the next frame.
REQ-027 CLEAR SHALL assert arr_clr for exactly one cycle and then go to FIRE.
REQ-028 FIRE SHALL assert arr_start for exactly one cycle and then go to WAIT.
REQ-029 Latency: last word accepted at edge t -> arr_clr high in cycle t+1, arr_start high in cycle t+2.
REQ-030 WAIT SHALL register arr_done and act only on a rising edge (previous value 0, current value 1); a level that is already high on entry SHALL NOT complete the run.
REQ-031 On that rising edge the loader SHALL capture arr_score into score, pulse score_valid for one cycle and go to LOAD_A; in_ready SHALL be 1 in the following cycle.
REQ-032 seq_a and seq_b SHALL remain stable from CLEAR through exit from WAIT.
REQ-033 score SHALL hold its value until the next capture.
REQ-034 cnt SHALL be $clog2(max(N,M)+1) bits wide and SHALL never exceed N in LOAD_A or M in LOAD_B.
REQ-035 Symbols and score SHALL pass through unmodified; no arithmetic is performed on data.

Reset
REQ-036 Assertion of reset SHALL immediately set the FSM to LOAD_A and cnt to 0.
REQ-037 Assertion of reset SHALL immediately clear seq_a, seq_b, score and the registered arr_done.
REQ-038 Assertion of reset SHALL immediately clear arr_clr, arr_start, score_valid and frame_err; in_ready SHALL read 1 once the FSM is in LOAD_A.
REQ-039 Reset asserted mid-frame or in WAIT SHALL abandon the operation; no pulse SHALL be emitted after reset is deasserted.

Verification
REQ-040 Nominal run: send 10 words 1..10 back-to-back, in_last on word 10 -> seq_a words = 1..5, seq_b words = 6..10; arr_clr high at t+1, arr_start high at t+2; arr_score=7 with arr_done rising -> score=7 and one score_valid pulse.
REQ-041 Early last: in_last on word 7 -> frame_err pulse, no arr_start; a following good frame completes normally.
REQ-042 Missing last: 10 words with in_last=0 -> frame_err pulse after word 10, FSM back in LOAD_A.
REQ-043 Stale done: arr_done held high through CLEAR and FIRE -> no completion; completion only after arr_done goes 0 and then returns to 1.
REQ-044 Backpressure: in_valid toggling randomly and words offered during WAIT -> no word accepted while in_ready=0; data order preserved.
REQ-045 Reset asserted at word 3 and again in WAIT -> all outputs 0; the next full frame runs correctly.
